// File: rtl/breakout_pkg.sv
// Shared types and helpers for the breakout brick column: coordinate width,
// ball direction and column FSM state encodings, and the saturating score add.
package breakout_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_U,
    DIR_D,
    DIR_L,
    DIR_R
  } dir_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESPOND,
    HOLDOFF
  } state_t;

  // The sum is formed at 17 bits so the carry shows whether the score overflowed.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/breakout_hit_classify.sv
// Combinational ball-vs-brick test for one row: overlap flag plus the bounce
// direction chosen by priority-ordered edge bands.
module breakout_hit_classify
  import breakout_pkg::*;
#(
  parameter int COL_X_LEFT  = 687,
  parameter int COL_X_RIGHT = 792,
  parameter int EDGE_DEPTH  = 4
) (
  input  logic [COORD_W-1:0] row_yt,
  input  logic [COORD_W-1:0] row_yb,
  input  logic [COORD_W-1:0] ball_x_l,
  input  logic [COORD_W-1:0] ball_x_r,
  input  logic [COORD_W-1:0] ball_y_t,
  input  logic [COORD_W-1:0] ball_y_b,
  output logic               overlap,
  output dir_t               dir
);

  localparam logic [COORD_W:0] XL = (COORD_W+1)'(COL_X_LEFT);
  localparam logic [COORD_W:0] XR = (COORD_W+1)'(COL_X_RIGHT);
  localparam logic [COORD_W:0] EW = (COORD_W+1)'(EDGE_DEPTH);

  logic in_d, in_u, in_r, in_l;

  // Band bounds are rearranged as additions at one extra bit so that an edge
  // band reaching below pixel 0 cannot wrap around.
  always_comb begin
    overlap = ({1'b0, ball_x_r} >= XL) && ({1'b0, ball_x_l} <= XR) &&
              (ball_y_b >= row_yt) && (ball_y_t <= row_yb);
    in_d = (({1'b0, ball_y_t} + EW) > {1'b0, row_yb}) && (ball_y_t <= row_yb);
    in_u = (ball_y_b >= row_yt) && ({1'b0, ball_y_b} < ({1'b0, row_yt} + EW));
    in_r = (({1'b0, ball_x_l} + EW) > XR) && ({1'b0, ball_x_l} <= XR);
    in_l = ({1'b0, ball_x_r} >= XL) && ({1'b0, ball_x_r} < (XL + EW));
    if (in_d)      dir = DIR_D;
    else if (in_u) dir = DIR_U;
    else if (in_r) dir = DIR_R;
    else if (in_l) dir = DIR_L;
    else           dir = DIR_D;
  end

endmodule

// File: rtl/breakout_block_column.sv
// One column of multi-hit bricks: scans rows sequentially after each ball
// update, damages the first live brick struck and tracks score and bricks left.
module breakout_block_column
  import breakout_pkg::*;
#(
  parameter int NUM_ROWS         = 8,
  parameter int COL_X_LEFT       = 687,
  parameter int COL_X_RIGHT      = 792,
  parameter int ROW_Y_TOP        = 4,
  parameter int ROW_HEIGHT       = 16,
  parameter int ROW_PITCH        = 23,
  parameter int EDGE_DEPTH       = 4,
  parameter int HIT_POINTS       = 1,
  parameter int POINTS_PER_BLOCK = 1,
  parameter int HOLDOFF_FRAMES   = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [COORD_W-1:0] ball_x_l,
  input  logic [COORD_W-1:0] ball_x_r,
  input  logic [COORD_W-1:0] ball_y_t,
  input  logic [COORD_W-1:0] ball_y_b,
  input  logic               ball_valid,
  output logic               moveU,
  output logic               moveD,
  output logic               moveL,
  output logic               moveR,
  output logic               hit_pulse,
  output logic [15:0]        col_count,
  output logic [4:0]         blocks_left,
  output logic               col_clear,
  output logic               col_on,
  output logic [1:0]         col_hp
);

  localparam int IDX_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  if (ROW_Y_TOP + (NUM_ROWS - 1) * ROW_PITCH + ROW_HEIGHT - 1 > 2047) begin : g_bad_geometry
    $error("breakout_block_column: bottom row extends past pixel 2047");
  end
  if (NUM_ROWS < 1 || NUM_ROWS > 16 || HIT_POINTS < 1 || HIT_POINTS > 3 ||
      HOLDOFF_FRAMES < 0 || HOLDOFF_FRAMES > 15) begin : g_bad_param
    $error("breakout_block_column: parameter out of range");
  end

  function automatic logic [COORD_W-1:0] row_top(input int r);
    return COORD_W'(ROW_Y_TOP + r * ROW_PITCH);
  endfunction

  function automatic logic [COORD_W-1:0] row_bot(input int r);
    return COORD_W'(ROW_Y_TOP + r * ROW_PITCH + ROW_HEIGHT - 1);
  endfunction

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   hit_row;
  dir_t               hit_dir;
  logic [3:0]         hold_cnt;
  logic [1:0]         hp [NUM_ROWS];
  logic [COORD_W-1:0] bx_l, bx_r, by_t, by_b;
  logic               cls_overlap;
  dir_t               cls_dir;
  logic               hit_now;
  logic               last_row;

  // A single classifier is shared by all rows; the scan index selects the bounds.
  breakout_hit_classify #(
    .COL_X_LEFT (COL_X_LEFT),
    .COL_X_RIGHT(COL_X_RIGHT),
    .EDGE_DEPTH (EDGE_DEPTH)
  ) u_classify (
    .row_yt  (row_top(int'(idx))),
    .row_yb  (row_bot(int'(idx))),
    .ball_x_l(bx_l),
    .ball_x_r(bx_r),
    .ball_y_t(by_t),
    .ball_y_b(by_b),
    .overlap (cls_overlap),
    .dir     (cls_dir)
  );

  assign hit_now  = cls_overlap && (hp[idx] != 2'd0);
  assign last_row = (idx == IDX_W'(NUM_ROWS - 1));
  assign col_clear = (blocks_left == 5'd0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Pulses are decoded from RESPOND and suppressed while reset is asserted.
  always_comb begin
    state_next = state;
    moveU      = 1'b0;
    moveD      = 1'b0;
    moveL      = 1'b0;
    moveR      = 1'b0;
    hit_pulse  = 1'b0;
    case (state)
      IDLE:    if (ball_valid) state_next = SCAN;
      SCAN: begin
        if (hit_now)       state_next = RESPOND;
        else if (last_row) state_next = IDLE;
      end
      RESPOND: begin
        state_next = (HOLDOFF_FRAMES == 0) ? IDLE : HOLDOFF;
        if (!reset) begin
          hit_pulse = 1'b1;
          case (hit_dir)
            DIR_U:   moveU = 1'b1;
            DIR_D:   moveD = 1'b1;
            DIR_L:   moveL = 1'b1;
            DIR_R:   moveR = 1'b1;
            default: ;
          endcase
        end
      end
      HOLDOFF: begin
        if (ball_valid && hold_cnt == 4'(HOLDOFF_FRAMES - 1)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx         <= '0;
      hit_row     <= '0;
      hit_dir     <= DIR_NONE;
      hold_cnt    <= 4'd0;
      col_count   <= 16'd0;
      blocks_left <= 5'(NUM_ROWS);
      bx_l        <= '0;
      bx_r        <= '0;
      by_t        <= '0;
      by_b        <= '0;
      for (int r = 0; r < NUM_ROWS; r++) hp[r] <= 2'(HIT_POINTS);
    end else begin
      case (state)
        IDLE: begin
          if (ball_valid) begin
            bx_l <= ball_x_l;
            bx_r <= ball_x_r;
            by_t <= ball_y_t;
            by_b <= ball_y_b;
            idx  <= '0;
          end
        end
        SCAN: begin
          if (hit_now) begin
            hit_row <= idx;
            hit_dir <= cls_dir;
          end else if (!last_row) begin
            idx <= idx + 1'b1;
          end
        end
        RESPOND: begin
          hp[hit_row] <= hp[hit_row] - 2'd1;
          hold_cnt    <= 4'd0;
          if (hp[hit_row] == 2'd1) begin
            blocks_left <= blocks_left - 5'd1;
            col_count   <= sat_add16(col_count, 16'(POINTS_PER_BLOCK));
          end
        end
        HOLDOFF: if (ball_valid) hold_cnt <= hold_cnt + 4'd1;
        default: ;
      endcase
    end
  end

  // Rows never overlap vertically, so at most one row can claim the pixel.
  always_comb begin
    col_on = 1'b0;
    col_hp = 2'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (pix_x >= COORD_W'(COL_X_LEFT) && pix_x <= COORD_W'(COL_X_RIGHT) &&
          pix_y >= row_top(r) && pix_y <= row_bot(r) && hp[r] != 2'd0) begin
        col_on = 1'b1;
        col_hp = hp[r];
      end
    end
  end

endmodule

// File: tb/tb_breakout_block_column.sv
// Directed bench for breakout_block_column: three instances cover the default,
// two-hit bricks and a large per-brick score.
module tb_breakout_block_column;

  logic        clk;
  logic        reset;
  logic [10:0] pix_x, pix_y;
  logic [10:0] bxl, bxr, byt, byb;
  logic [2:0]  bv;
  logic [2:0]  move_u, move_d, move_l, move_r, hit_p, col_clear, col_on;
  logic [15:0] col_count [3];
  logic [4:0]  blocks_left [3];
  logic [1:0]  col_hp [3];

  int n_checks = 0;
  int n_fail   = 0;

  breakout_block_column dut0 (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(bxl), .ball_x_r(bxr), .ball_y_t(byt), .ball_y_b(byb), .ball_valid(bv[0]),
    .moveU(move_u[0]), .moveD(move_d[0]), .moveL(move_l[0]), .moveR(move_r[0]),
    .hit_pulse(hit_p[0]), .col_count(col_count[0]), .blocks_left(blocks_left[0]),
    .col_clear(col_clear[0]), .col_on(col_on[0]), .col_hp(col_hp[0])
  );

  breakout_block_column #(.HIT_POINTS(2)) dut1 (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(bxl), .ball_x_r(bxr), .ball_y_t(byt), .ball_y_b(byb), .ball_valid(bv[1]),
    .moveU(move_u[1]), .moveD(move_d[1]), .moveL(move_l[1]), .moveR(move_r[1]),
    .hit_pulse(hit_p[1]), .col_count(col_count[1]), .blocks_left(blocks_left[1]),
    .col_clear(col_clear[1]), .col_on(col_on[1]), .col_hp(col_hp[1])
  );

  breakout_block_column #(.POINTS_PER_BLOCK(20000)) dut2 (
    .clk(clk), .reset(reset), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(bxl), .ball_x_r(bxr), .ball_y_t(byt), .ball_y_b(byb), .ball_valid(bv[2]),
    .moveU(move_u[2]), .moveD(move_d[2]), .moveL(move_l[2]), .moveR(move_r[2]),
    .hit_pulse(hit_p[2]), .col_count(col_count[2]), .blocks_left(blocks_left[2]),
    .col_clear(col_clear[2]), .col_on(col_on[2]), .col_hp(col_hp[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [4:0] pulses(input int d);
    return {move_u[d], move_d[d], move_l[d], move_r[d], hit_p[d]};
  endfunction

  task automatic set_ball(input int xl, input int xr, input int yt, input int yb);
    bxl = 11'(xl); bxr = 11'(xr); byt = 11'(yt); byb = 11'(yb);
  endtask

  task automatic set_pix(input int x, input int y);
    pix_x = 11'(x); pix_y = 11'(y);
    #1;
  endtask

  // Strobes ball_valid in cycle 0 and watches pulses over cycles 1..max_cyc.
  task automatic strobe_watch(input int d, input int max_cyc,
                              output int npulse, output int pcyc, output logic [4:0] pv);
    logic [4:0] cur;
    npulse = 0; pcyc = -1; pv = 5'b0;
    @(negedge clk); bv[d] = 1'b1;
    @(negedge clk); bv[d] = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      if (c > 1) @(negedge clk);
      #1;
      cur = pulses(d);
      if (cur != 5'b0) begin
        npulse++; pcyc = c; pv = cur;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; bv = 3'b0;
    set_ball(0, 0, 0, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_pix(700, 10);
    n_checks++; if (col_on[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_col_on: got %0b expected 1", col_on[0]); end
    n_checks++; if (col_hp[0] !== 2'd1) begin n_fail++; $display("[TB] FAIL reset_col_hp: got %0d expected 1", col_hp[0]); end
    n_checks++; if (blocks_left[0] !== 5'd8) begin n_fail++; $display("[TB] FAIL reset_blocks_left: got %0d expected 8", blocks_left[0]); end
    n_checks++; if (col_count[0] !== 16'd0) begin n_fail++; $display("[TB] FAIL reset_col_count: got %0d expected 0", col_count[0]); end
    n_checks++; if (pulses(0) !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_pulses: got %b expected 00000", pulses(0)); end
    n_checks++; if (col_clear[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_col_clear: got %0b expected 0", col_clear[0]); end
    n_checks++; if (col_hp[1] !== 2'd2) begin n_fail++; $display("[TB] FAIL reset_hp2_col_hp: got %0d expected 2", col_hp[1]); end
  endtask

  task automatic test_single_hit();
    int np, pc; logic [4:0] pv;
    set_ball(740, 747, 40, 47);
    strobe_watch(0, 6, np, pc, pv);
    n_checks++; if (np !== 1) begin n_fail++; $display("[TB] FAIL hit_pulse_count: got %0d expected 1", np); end
    n_checks++; if (pc !== 3) begin n_fail++; $display("[TB] FAIL hit_latency: got cycle %0d expected 3", pc); end
    n_checks++; if (pv !== 5'b01001) begin n_fail++; $display("[TB] FAIL hit_dir: got %b expected 01001", pv); end
    n_checks++; if (blocks_left[0] !== 5'd7) begin n_fail++; $display("[TB] FAIL hit_blocks_left: got %0d expected 7", blocks_left[0]); end
    n_checks++; if (col_count[0] !== 16'd1) begin n_fail++; $display("[TB] FAIL hit_col_count: got %0d expected 1", col_count[0]); end
    set_pix(700, 30);
    n_checks++; if (col_on[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL hit_row1_off: got %0b expected 0", col_on[0]); end
  endtask

  task automatic test_holdoff_dead_row();
    int np, pc; logic [4:0] pv;
    int tot;
    tot = 0;
    for (int i = 0; i < 2; i++) begin
      strobe_watch(0, 4, np, pc, pv);
      tot += np;
    end
    n_checks++; if (tot !== 0) begin n_fail++; $display("[TB] FAIL holdoff_drain_pulses: got %0d expected 0", tot); end
    set_ball(682, 689, 52, 59);
    strobe_watch(0, 6, np, pc, pv);
    n_checks++; if (pv !== 5'b00101 || np !== 1) begin n_fail++; $display("[TB] FAIL left_edge_dir: got %b x%0d expected 00101 x1", pv, np); end
    n_checks++; if (pc !== 4) begin n_fail++; $display("[TB] FAIL left_edge_latency: got cycle %0d expected 4", pc); end
    n_checks++; if (blocks_left[0] !== 5'd6) begin n_fail++; $display("[TB] FAIL left_blocks_left: got %0d expected 6", blocks_left[0]); end
    strobe_watch(0, 6, np, pc, pv);
    n_checks++; if (np !== 0) begin n_fail++; $display("[TB] FAIL holdoff_repeat: got %0d pulses expected 0", np); end
    strobe_watch(0, 6, np, pc, pv);
    n_checks++; if (np !== 0) begin n_fail++; $display("[TB] FAIL holdoff_end_strobe: got %0d pulses expected 0", np); end
    strobe_watch(0, 12, np, pc, pv);
    n_checks++; if (np !== 0) begin n_fail++; $display("[TB] FAIL dead_row_scan: got %0d pulses expected 0", np); end
    n_checks++; if (blocks_left[0] !== 5'd6) begin n_fail++; $display("[TB] FAIL dead_row_blocks_left: got %0d expected 6", blocks_left[0]); end
    set_ball(740, 747, 80, 87);
    strobe_watch(0, 8, np, pc, pv);
    n_checks++; if (pv !== 5'b01001 || pc !== 5) begin n_fail++; $display("[TB] FAIL fallback_dir_row3: got %b cycle %0d expected 01001 cycle 5", pv, pc); end
  endtask

  task automatic test_multi_hit();
    int np, pc; logic [4:0] pv;
    set_ball(740, 747, 16, 23);
    strobe_watch(1, 6, np, pc, pv);
    n_checks++; if (pv !== 5'b01001 || pc !== 2) begin n_fail++; $display("[TB] FAIL hp2_first_hit: got %b cycle %0d expected 01001 cycle 2", pv, pc); end
    set_pix(700, 10);
    n_checks++; if (col_hp[1] !== 2'd1) begin n_fail++; $display("[TB] FAIL hp2_col_hp: got %0d expected 1", col_hp[1]); end
    n_checks++; if (col_count[1] !== 16'd0) begin n_fail++; $display("[TB] FAIL hp2_count_first: got %0d expected 0", col_count[1]); end
    n_checks++; if (blocks_left[1] !== 5'd8) begin n_fail++; $display("[TB] FAIL hp2_blocks_first: got %0d expected 8", blocks_left[1]); end
    strobe_watch(1, 4, np, pc, pv);
    strobe_watch(1, 4, np, pc, pv);
    strobe_watch(1, 6, np, pc, pv);
    n_checks++; if (pv !== 5'b01001 || pc !== 2) begin n_fail++; $display("[TB] FAIL hp2_second_hit: got %b cycle %0d expected 01001 cycle 2", pv, pc); end
    set_pix(700, 10);
    n_checks++; if (col_count[1] !== 16'd1) begin n_fail++; $display("[TB] FAIL hp2_count_second: got %0d expected 1", col_count[1]); end
    n_checks++; if (col_on[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL hp2_row0_off: got %0b expected 0", col_on[1]); end
    n_checks++; if (blocks_left[1] !== 5'd7) begin n_fail++; $display("[TB] FAIL hp2_blocks_second: got %0d expected 7", blocks_left[1]); end
  endtask

  task automatic test_saturation_clear();
    int np, pc; logic [4:0] pv;
    logic [15:0] exp_count;
    set_ball(740, 747, 0, 200);
    for (int k = 0; k < 8; k++) begin
      strobe_watch(2, 12, np, pc, pv);
      n_checks++; if (np !== 1 || pc !== k + 2 || pv !== 5'b01001) begin n_fail++; $display("[TB] FAIL sat_hit_row%0d: got %b cycle %0d x%0d expected 01001 cycle %0d x1", k, pv, pc, np, k + 2); end
      exp_count = (k < 3) ? 16'(20000 * (k + 1)) : 16'hFFFF;
      n_checks++; if (col_count[2] !== exp_count) begin n_fail++; $display("[TB] FAIL sat_count_row%0d: got %0d expected %0d", k, col_count[2], exp_count); end
      strobe_watch(2, 4, np, pc, pv);
      strobe_watch(2, 4, np, pc, pv);
    end
    set_pix(700, 10);
    n_checks++; if (col_clear[2] !== 1'b1) begin n_fail++; $display("[TB] FAIL clear_flag: got %0b expected 1", col_clear[2]); end
    n_checks++; if (blocks_left[2] !== 5'd0) begin n_fail++; $display("[TB] FAIL clear_blocks_left: got %0d expected 0", blocks_left[2]); end
    n_checks++; if (col_on[2] !== 1'b0 || col_hp[2] !== 2'd0) begin n_fail++; $display("[TB] FAIL clear_pixel: got on=%0b hp=%0d expected on=0 hp=0", col_on[2], col_hp[2]); end
    strobe_watch(2, 12, np, pc, pv);
    n_checks++; if (np !== 0) begin n_fail++; $display("[TB] FAIL clear_no_pulse: got %0d pulses expected 0", np); end
  endtask

  task automatic test_reset_abort();
    int np, pc; logic [4:0] pv;
    int tot;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_ball(740, 747, 40, 47);
    tot = 0;
    @(negedge clk); bv[0] = 1'b1;
    @(negedge clk); bv[0] = 1'b0;
    #1; if (pulses(0) != 5'b0) tot++;
    @(negedge clk); reset = 1'b1;
    #1; if (pulses(0) != 5'b0) tot++;
    @(negedge clk); reset = 1'b0;
    #1; if (pulses(0) != 5'b0) tot++;
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk); #1;
      if (pulses(0) != 5'b0) tot++;
    end
    n_checks++; if (tot !== 0) begin n_fail++; $display("[TB] FAIL abort_no_pulse: got %0d pulse cycles expected 0", tot); end
    set_pix(700, 30);
    n_checks++; if (col_hp[0] !== 2'd1) begin n_fail++; $display("[TB] FAIL abort_row1_hp: got %0d expected 1", col_hp[0]); end
    n_checks++; if (blocks_left[0] !== 5'd8) begin n_fail++; $display("[TB] FAIL abort_blocks_left: got %0d expected 8", blocks_left[0]); end
    strobe_watch(0, 6, np, pc, pv);
    n_checks++; if (np !== 1 || pc !== 3 || pv !== 5'b01001) begin n_fail++; $display("[TB] FAIL abort_then_idle_hit: got %b cycle %0d x%0d expected 01001 cycle 3 x1", pv, pc, np); end
  endtask

  initial begin
    reset = 1'b1;
    bv = 3'b0;
    pix_x = 11'd0; pix_y = 11'd0;
    set_ball(0, 0, 0, 0);
    test_reset();
    test_single_hit();
    test_holdoff_dead_row();
    test_multi_hit();
    test_saturation_clear();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
